// File: rtl/dp_muxnds_skid_pkg.sv
// dp_muxnds_skid_pkg
//   Shared definitions for the decoded-select skid mux: buffer state
//   encodings and the supported range of the NUM_IN parameter.
package dp_muxnds_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    localparam int NUM_IN_MIN = 2;
    localparam int NUM_IN_MAX = 16;

endpackage

// File: rtl/dp_muxnds_skid_dec.sv
// dp_onecold_dec
//   Combinational N-way mux driven by active-low one-cold selects.
//   Flags any select code that does not have exactly one bit at 0.
//   Optional macro DP_MUXNDS_XPROP_EN: illegal codes produce X data
//   (except all-ones selects over identical inputs, which produce that
//   common value); otherwise illegal codes produce all-zeros.
// Ports:
//   sel_l    in   NUM_IN        active-low decoded selects
//   in_data  in   NUM_IN*SIZE   input k at [k*SIZE +: SIZE]
//   dout     out  SIZE          selected word
//   illegal  out  1             select code is not one-cold
module dp_onecold_dec #(
    parameter int SIZE   = 1,
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN-1:0]      sel_l,
    input  logic [NUM_IN*SIZE-1:0] in_data,
    output logic [SIZE-1:0]        dout,
    output logic                   illegal
);

    logic [NUM_IN-1:0] sel_h;
    logic [SIZE-1:0]   mux_or;

    assign sel_h = ~sel_l;

    // One-hot test on the active-high form: nonzero and no second bit set.
    assign illegal = (sel_h == '0) || ((sel_h & (sel_h - NUM_IN'(1))) != '0);

    always_comb begin
        mux_or = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!sel_l[k]) mux_or = mux_or | in_data[k*SIZE +: SIZE];
        end
    end

`ifdef DP_MUXNDS_XPROP_EN
    logic all_same;

    always_comb begin
        all_same = 1'b1;
        for (int k = 1; k < NUM_IN; k++) begin
            if (in_data[k*SIZE +: SIZE] != in_data[SIZE-1:0]) all_same = 1'b0;
        end
    end

    always_comb begin
        if (!illegal)
            dout = mux_or;
        else if ((&sel_l) && all_same)
            dout = in_data[SIZE-1:0];
        else
            dout = {SIZE{1'bx}};
    end
`else
    assign dout = illegal ? '0 : mux_or;
`endif

endmodule

// File: rtl/dp_muxnds_skid.sv
// dp_muxnds_skid
//   N-way one-cold mux with a registered output behind a 2-entry skid
//   buffer (valid/ready both sides), plus illegal-select tracking with a
//   sticky flag and a saturating counter.
//   Optional macro DP_MUXNDS_XPROP_EN selects X data for illegal selects
//   (see dp_onecold_dec); error tracking is unaffected.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_data, sel_l    mux inputs and active-low selects
//   in_vld / in_rdy   upstream handshake (in_rdy is a flop)
//   dout / dout_vld   registered output and its valid
//   dout_rdy          downstream ready
//   sel_err           sticky illegal-select flag
//   sel_err_cnt       saturating illegal-select count
//   err_clr           clears sel_err and sel_err_cnt
module dp_muxnds_skid
    import dp_muxnds_skid_pkg::*;
#(
    parameter int SIZE   = 1,
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_IN*SIZE-1:0] in_data,
    input  logic [NUM_IN-1:0]      sel_l,
    input  logic                   in_vld,
    output logic                   in_rdy,
    output logic [SIZE-1:0]        dout,
    output logic                   dout_vld,
    input  logic                   dout_rdy,
    output logic                   sel_err,
    output logic [CNT_W-1:0]       sel_err_cnt,
    input  logic                   err_clr
);

    if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
        $error("dp_muxnds_skid: NUM_IN out of supported range");
    end

    skid_state_t      state, state_nxt;
    logic [SIZE-1:0]  main_q, main_nxt;
    logic [SIZE-1:0]  skid_q, skid_nxt;
    logic             rdy_q, rdy_nxt;
    logic             err_q, err_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    logic [SIZE-1:0]  mux_val;
    logic             mux_illegal;
    logic             accept, xfer;

    dp_onecold_dec #(.SIZE(SIZE), .NUM_IN(NUM_IN)) u_dec (
        .sel_l   (sel_l),
        .in_data (in_data),
        .dout    (mux_val),
        .illegal (mux_illegal)
    );

    assign in_rdy      = rdy_q;
    assign dout        = main_q;
    assign dout_vld    = (state != ST_EMPTY);
    assign sel_err     = err_q;
    assign sel_err_cnt = cnt_q;

    assign accept = in_vld && rdy_q;
    assign xfer   = dout_vld && dout_rdy;

    // Buffer control
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        rdy_nxt   = rdy_q;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_ONE;
                    main_nxt  = mux_val;
                end
            end
            ST_ONE: begin
                if (accept && !xfer) begin
                    state_nxt = ST_TWO;
                    skid_nxt  = mux_val;
                    rdy_nxt   = 1'b0;
                end else if (accept) begin
                    main_nxt  = mux_val;
                end else if (xfer) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_rdy is low here, so nothing can be accepted.
                if (xfer) begin
                    state_nxt = ST_ONE;
                    main_nxt  = skid_q;
                    rdy_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
                rdy_nxt   = 1'b1;
            end
        endcase
    end

    // Error tracking: a clear is applied first, then a coincident illegal
    // accept counts on top of the cleared value.
    always_comb begin
        err_nxt = err_clr ? 1'b0 : err_q;
        cnt_nxt = err_clr ? '0   : cnt_q;
        if (accept && mux_illegal) begin
            err_nxt = 1'b1;
            if (cnt_nxt != {CNT_W{1'b1}}) cnt_nxt = cnt_nxt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
            rdy_q  <= 1'b1;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
            rdy_q  <= rdy_nxt;
            err_q  <= err_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

endmodule

// File: doc/dp_muxnds_skid.md
Name: dp_muxnds_skid

Overview:
- Parametrised successor to the fixed 3/4/5/8-way decoded-select datapath muxes.
- N-way mux with active-low one-cold selects and a registered output behind a 2-entry skid buffer, using a valid/ready handshake.
- Detects illegal select codes: sticky error flag plus saturating error counter.
- Sits between datapath stages that need a mux plus a pipeline cut with backpressure.

Parameters:
- SIZE, 1, data width per input.
- NUM_IN, 4, number of mux inputs; legal range 2..16.
- CNT_W, 4, width of the illegal-select counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*SIZE  concatenated inputs; input k occupies bits [k*SIZE +: SIZE].
- sel_l  input  NUM_IN  decoded active-low selects; a legal code has exactly one bit at 0.
- in_vld  input  1  upstream data/select valid.
- in_rdy  output  1  block can accept; driven directly from a flop.
- dout  output  SIZE  selected data, registered.
- dout_vld  output  1  dout valid.
- dout_rdy  input  1  downstream accepts dout.
- sel_err  output  1  sticky: an illegal select was accepted.
- sel_err_cnt  output  CNT_W  saturating count of accepted illegal selects.
- err_clr  input  1  clears sel_err and sel_err_cnt.

Behaviour:
- Reset values: in_rdy=1, dout_vld=0, dout=0, sel_err=0, sel_err_cnt=0, skid register=0.
- Handshakes:
  - Accept occurs when in_vld && in_rdy.
  - Output transfer occurs when dout_vld && dout_rdy.
- Mux value:
  - Legal select: in_data of the input whose sel_l bit is 0.
  - Illegal select (all ones, or two or more zeros): all-zeros data (see Optional Feature).
- Latency: an accepted word appears on dout the next cycle when the main register is empty or draining.
- State machine, one-hot or binary, with states EMPTY, ONE and TWO:
  - EMPTY: accept -> ONE, main register <= mux value.
  - ONE, accept and no transfer -> TWO: skid register <= mux value; in_rdy <= 0.
  - ONE, accept and transfer -> ONE: main register <= mux value.
  - ONE, transfer and no accept -> EMPTY.
  - ONE, neither -> hold.
  - TWO, transfer -> ONE: main register <= skid register; in_rdy <= 1.
  - TWO, no transfer -> hold. No accept is possible because in_rdy=0.
- Ordering and stability:
  - Strict FIFO order; no data loss; no duplication.
  - dout and dout_vld are stable while dout_vld && !dout_rdy.
- Error tracking:
  - On accept with an illegal select: sel_err <= 1; sel_err_cnt increments and saturates at 2^CNT_W-1.
  - Selects are ignored when no accept occurs.
- err_clr:
  - Clears both sel_err and sel_err_cnt next cycle.
  - If err_clr coincides with an illegal accept, the clear wins, then the event is applied: result sel_err=1, cnt=1.
- Reset mid-operation: all buffered data is discarded and the block returns to EMPTY next cycle. rst overrides err_clr and all handshakes.

Optional Feature:
- Macro: DP_MUXNDS_XPROP_EN.
- Defined: an illegal select loads {SIZE{1'bx}} into the data register, for simulation X-propagation matching the legacy muxes.
  - Exception: all select bits equal to 1 while every input is identical loads that common value.
  - Error flag and counter behave identically.
- Undefined (synthesis default): an illegal select loads all-zeros.

Decomposition:
- Shared include/package holds:
  - State encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - NUM_IN legal-range constants.
- One natural sub-module: dp_onecold_dec (combinational).
  - Inputs: sel_l, in_data.
  - Outputs: the muxed word and an illegal flag.
  - Reusable by other wide decoded muxes.

Test Plan:
- NUM_IN=4, SIZE=8, dout_rdy=1; stream sel_l=1110,1101,1011,0111 with inputs A0,B1,C2,D3 -> dout A0,B1,C2,D3 on consecutive cycles, one-cycle latency, in_rdy stays 1.
- dout_rdy=0 after first word 11 and two more valid words 22, 33 offered -> TWO reached after 22, in_rdy=0, 33 held upstream; release dout_rdy -> 11,22,33 in order, no gaps after release.
- Accept sel_l=1111 then sel_l=1100 -> two zero words out; sel_err=1; sel_err_cnt=2.
- CNT_W=2; 5 illegal accepts -> sel_err_cnt saturates at 3; err_clr with a simultaneous illegal accept -> cnt=1, sel_err=1; err_clr alone -> cnt=0, sel_err=0.
- rst asserted while in TWO with dout_rdy=0 -> next cycle dout_vld=0, in_rdy=1, dout=0, counters 0; buffered words never appear.
- Illegal select offered with in_vld=0, and separately with in_rdy=0 -> no error-counter change.
